fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage of the 5-stage RISC-V pipeline. It sits directly upstream of the IF/ID pipeline register and owns the program counter. It issues word requests to instruction memory and absorbs the 1-cycle memory latency in a 2-entry buffer. It presents (PC, instruction) pairs to IF/ID, honours pipeline stalls and flushes the path on branch/jump redirects.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0
- NOP_INSTR, 32'h0000_0013, instruction driven when no valid entry (addi x0,x0,0)

Ports:
- clock  in  1  single clock; all state updates on posedge
- reset  in  1  asynchronous, active-high; clears all state immediately
- stall  in  1  hazard unit: IF/ID must not advance this cycle
- redirect_valid  in  1  taken branch/jump resolved downstream
- redirect_pc  in  32  redirect target; bits [1:0] ignored (treated as 00)
- imem_req  out  1  fetch request
- imem_addr  out  32  word address of request (byte address, [1:0]=00)
- imem_gnt  in  1  memory accepts request this cycle
- imem_rvalid  in  1  read data valid; asserted exactly 1 cycle after each grant
- imem_rdata  in  32  instruction word
- fetch_valid  out  1  head entry valid
- fetch_pc  out  32  PC of head entry (feeds IF/ID PC_IN)
- fetch_instr  out  32  instruction of head entry (feeds IF/ID Mem_In)

## Operation
- State: pc_next (32), FSM {BOOT, RUN}, buffer of 2 entries {pc, instr} with rd_ptr/wr_ptr (1 bit) and count (0..2), in-flight record {inflight, inflight_pc, kill}.
- FSM: reset -> BOOT; BOOT -> RUN after one cycle, issuing no request in BOOT; RUN is held until the next reset.
- pop = fetch_valid && !stall && !redirect_valid.
- Request, in RUN with no redirect: imem_req = (count + inflight - pop) < 2. imem_addr = pc_next.
- Grant (imem_req && imem_gnt): set inflight=1, inflight_pc=pc_next, kill=0, then pc_next += 4. The addition is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- No grant: pc_next is held, and req/addr stay stable next cycle unless a redirect occurs.
- Response cycle (inflight=1): if imem_rvalid && !kill, write {inflight_pc, imem_rdata} at wr_ptr. inflight clears unless a new grant occurs in the same cycle.
- Redirect (any state, priority over stall and pop):
  - count←0, pointers←0.
  - kill←1 on any in-flight request, so its response is dropped.
  - pc_next←{redirect_pc[31:2],2'b00}.
  - imem_req=0 in the redirect cycle.
- Outputs:
  - fetch_valid = (count != 0).
  - fetch_pc/fetch_instr = head entry when valid, else 32'h0 / NOP_INSTR.
- Simultaneous write and pop: count unchanged, both pointers advance.
- Count never exceeds 2; the request rule guarantees that a write never lands on a full buffer.
- Reset (asynchronous, any time):
  - FSM=BOOT, pc_next=RESET_PC, count=0, inflight=0, kill=0.
  - Outputs: imem_req=0, imem_addr=RESET_PC, fetch_valid=0, fetch_pc=0, fetch_instr=NOP_INSTR.
  - Responses after reset for pre-reset grants are ignored, because inflight=0.

## Timing
- First request: cycle 1 after reset deasserts (cycle 0 is BOOT).
- Grant at cycle T -> rvalid at T+1 -> fetch_valid with that entry at T+2.
- Steady state with imem_gnt=1 and stall=0: one instruction per cycle, PC increments by 4.
- Redirect asserted in cycle N:
  - fetch_valid=0 from N+1.
  - Request to target at N+1 (granted) -> target visible at N+3.
  - Redirect penalty is 3 cycles measured at the output.
- Stall: head entry held unchanged. Requests continue until count+inflight reaches 2, then imem_req=0 until a pop.
- Redirect and stall in the same cycle: the redirect wins.

## Test plan
- Reset release, imem_gnt=1, rdata=addr^32'hA5A5_0000, stall=0:
  - imem_addr=0,4,8,... from cycle 1.
  - fetch_valid from cycle 3 with fetch_pc 0,4,8 and matching instr.
  - No gaps.
- stall high for 5 cycles in steady state:
  - Head entry held.
  - Exactly 2 entries buffered, then imem_req=0.
  - On release, PCs resume with no duplicate and no skip.
- redirect_valid with redirect_pc=32'h0000_0103 while one request is in flight:
  - In-flight response dropped.
  - Next imem_addr=32'h100.
  - fetch_pc=32'h100 three cycles after the redirect.
- imem_gnt low for 3 cycles:
  - imem_addr stable and imem_req held.
  - fetch_valid drops after the buffer drains.
  - Resumes in order.
- Wrap and reset:
  - RESET_PC=32'hFFFF_FFF8: fetch_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
  - Assert reset mid-stream with rvalid pulsing: outputs reach reset values immediately, and no stale entry appears after release.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues word fetches, and buffers up to two
// (pc, instr) pairs ahead of the IF/ID register across the 1-cycle memory latency.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        fetch_valid,
    output logic [31:0] fetch_pc,
    output logic [31:0] fetch_instr
);

    localparam logic [0:0] StBoot = 1'b0;
    localparam logic [0:0] StRun  = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [31:0] pc_next_q, pc_next_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [1:0]  count_q, count_d;
    logic        inflight_q, inflight_d;
    logic [31:0] inflight_pc_q, inflight_pc_d;
    logic        kill_q, kill_d;
    logic [31:0] buf_pc_q    [2];
    logic [31:0] buf_instr_q [2];

    logic       pop;
    logic       grant;
    logic       write;
    logic [2:0] occupancy;
    logic       unused_redirect_bits;

    assign unused_redirect_bits = ^redirect_pc[1:0];

    assign fetch_valid = (count_q != 2'd0);
    assign pop         = fetch_valid && !stall && !redirect_valid;
    assign occupancy   = {1'b0, count_q} + {2'b00, inflight_q};

    // Outstanding work (buffered + in flight) after this cycle's pop must stay below 2,
    // so a returning response always has a free slot.
    assign imem_req  = (state_q == StRun) && !redirect_valid
                       && (occupancy < (3'd2 + {2'b00, pop}));
    assign imem_addr = pc_next_q;
    assign grant     = imem_req && imem_gnt;
    assign write     = inflight_q && imem_rvalid && !kill_q && !redirect_valid;

    assign fetch_pc    = fetch_valid ? buf_pc_q[rd_ptr_q]    : 32'h0;
    assign fetch_instr = fetch_valid ? buf_instr_q[rd_ptr_q] : NOP_INSTR;

    always_comb begin
        state_d       = StRun;
        pc_next_d     = pc_next_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        inflight_d    = grant;
        inflight_pc_d = inflight_pc_q;
        kill_d        = kill_q;

        if (redirect_valid) begin
            pc_next_d = {redirect_pc[31:2], 2'b00};
            rd_ptr_d  = 1'b0;
            wr_ptr_d  = 1'b0;
            count_d   = 2'd0;
            if (inflight_q) begin
                kill_d = 1'b1;
            end
        end else begin
            if (grant) begin
                inflight_pc_d = pc_next_q;
                kill_d        = 1'b0;
                pc_next_d     = pc_next_q + 32'd4;
            end
            if (write) begin
                wr_ptr_d = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({write, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= StBoot;
            pc_next_q     <= RESET_PC;
            rd_ptr_q      <= 1'b0;
            wr_ptr_q      <= 1'b0;
            count_q       <= 2'd0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'h0;
            kill_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_next_q     <= pc_next_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            kill_q        <= kill_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            buf_pc_q[0]    <= 32'h0;
            buf_pc_q[1]    <= 32'h0;
            buf_instr_q[0] <= NOP_INSTR;
            buf_instr_q[1] <= NOP_INSTR;
        end else if (write) begin
            buf_pc_q[wr_ptr_q]    <= inflight_pc_q;
            buf_instr_q[wr_ptr_q] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a transaction-level queue model predicts the delivered (pc, instr)
// stream and the request handshake; a second instance checks PC wrap from a high RESET_PC.
module tb_fetch_stage;

    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    logic        clock = 1'b0;
    logic        reset, stall, redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        fetch_valid;
    logic [31:0] fetch_pc, fetch_instr;

    logic        req2, rvalid2, valid2;
    logic [31:0] addr2, rdata2, pc2, instr2;

    always #5 clock = ~clock;

    fetch_stage dut (
        .clock(clock), .reset(reset), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_instr(fetch_instr)
    );

    fetch_stage #(.RESET_PC(WRAP_PC), .NOP_INSTR(NOP)) dut_wrap (
        .clock(clock), .reset(reset), .stall(1'b0),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .imem_req(req2), .imem_addr(addr2), .imem_gnt(1'b1),
        .imem_rvalid(rvalid2), .imem_rdata(rdata2),
        .fetch_valid(valid2), .fetch_pc(pc2), .fetch_instr(instr2)
    );

    typedef struct {
        logic [31:0] pc;
        int          vis;
    } ent_t;

    // Every granted, not-yet-flushed, not-yet-consumed fetch, oldest first
    ent_t        q[$];
    logic        m_run;
    logic [31:0] m_req_pc;
    int          cyc, s_cyc;
    logic        s_req, s_valid, s2_valid;
    logic [31:0] s_addr, s_pc, s_instr, s2_pc;
    logic        e_req, e_valid;
    logic [31:0] e_addr, e_pc, e_instr;
    int          n_checks = 0;
    int          n_errors = 0;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic model_reset();
        q.delete();
        m_run    = 1'b0;
        m_req_pc = 32'h0;
        cyc      = 0;
    endtask

    // One clock cycle: sample at negedge, predict, advance model, then answer grants.
    task automatic tick();
        logic        pop, g, g2;
        logic [31:0] ga, ga2;
        @(negedge clock);
        s_req = imem_req; s_addr = imem_addr;
        s_valid = fetch_valid; s_pc = fetch_pc; s_instr = fetch_instr;
        s2_valid = valid2; s2_pc = pc2;
        s_cyc = cyc;
        e_valid = 1'b0; e_pc = 32'h0; e_instr = NOP;
        if (q.size() > 0) begin
            if (q[0].vis <= cyc) begin
                e_valid = 1'b1; e_pc = q[0].pc; e_instr = mem(q[0].pc);
            end
        end
        pop    = e_valid && !stall && !redirect_valid;
        e_req  = m_run && !reset && !redirect_valid && ((q.size() - int'(pop)) < 2);
        e_addr = m_req_pc;
        g  = imem_req && imem_gnt; ga  = imem_addr;
        g2 = req2;                 ga2 = addr2;
        if (reset) begin
            model_reset();
        end else begin
            if (redirect_valid) begin
                q.delete();
                m_req_pc = {redirect_pc[31:2], 2'b00};
            end else begin
                if (pop) void'(q.pop_front());
                if (e_req && imem_gnt) begin
                    q.push_back('{m_req_pc, cyc + 2});
                    m_req_pc = m_req_pc + 32'd4;
                end
            end
            m_run = 1'b1;
            cyc++;
        end
        @(posedge clock);
        #1;
        imem_rvalid = g;
        imem_rdata  = g ? mem(ga) : $urandom();
        rvalid2     = g2;
        rdata2      = mem(ga2);
    endtask

    task automatic test_reset();
        reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        rvalid2 = 1'b0; rdata2 = 32'h0;
        model_reset();
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h0 || fetch_valid !== 1'b0
            || fetch_pc !== 32'h0 || fetch_instr !== NOP) begin
            n_errors++;
            $display("FAIL reset_outputs: got req=%b addr=%h v=%b pc=%h i=%h, want 0/0/0/0/%h",
                     imem_req, imem_addr, fetch_valid, fetch_pc, fetch_instr, NOP);
        end
        n_checks++;
        if (req2 !== 1'b0 || addr2 !== WRAP_PC || valid2 !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_wrap_inst: got req=%b addr=%h v=%b, want 0/%h/0",
                     req2, addr2, valid2, WRAP_PC);
        end
        tick();
        tick();
    endtask

    task automatic test_steady();
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            n_checks++;
            if (s_valid !== e_valid || s_pc !== e_pc || s_instr !== e_instr) begin
                n_errors++;
                $display("FAIL steady_out cyc %0d: got v=%b pc=%h i=%h, want v=%b pc=%h i=%h",
                         s_cyc, s_valid, s_pc, s_instr, e_valid, e_pc, e_instr);
            end
            n_checks++;
            if (s_req !== e_req || (e_req && s_addr !== e_addr)) begin
                n_errors++;
                $display("FAIL steady_req cyc %0d: got req=%b addr=%h, want req=%b addr=%h",
                         s_cyc, s_req, s_addr, e_req, e_addr);
            end
            if (s_cyc >= 1) begin
                n_checks++;
                if (s_req !== 1'b1 || s_addr !== 32'(4 * (s_cyc - 1))) begin
                    n_errors++;
                    $display("FAIL steady_addr cyc %0d: got req=%b addr=%h, want 1/%h",
                             s_cyc, s_req, s_addr, 32'(4 * (s_cyc - 1)));
                end
            end
            if (s_cyc >= 3) begin
                n_checks++;
                if (s_valid !== 1'b1 || s_pc !== 32'(4 * (s_cyc - 3))) begin
                    n_errors++;
                    $display("FAIL steady_pc cyc %0d: got v=%b pc=%h, want 1/%h",
                             s_cyc, s_valid, s_pc, 32'(4 * (s_cyc - 3)));
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] held;
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 0) held = s_pc;
            n_checks++;
            if (s_valid !== e_valid || s_pc !== e_pc || s_instr !== e_instr
                || s_req !== e_req || s_valid !== 1'b1 || s_pc !== held) begin
                n_errors++;
                $display("FAIL stall_hold cyc %0d: got v=%b pc=%h req=%b, want v=1 pc=%h req=%b",
                         s_cyc, s_valid, s_pc, s_req, held, e_req);
            end
        end
        n_checks++;
        if (s_req !== 1'b0) begin
            n_errors++;
            $display("FAIL stall_req_off: got req=%b, want 0", s_req);
        end
        stall = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++;
            if (s_valid !== e_valid || s_pc !== e_pc || s_instr !== e_instr
                || s_pc !== held + 32'(4 * i)) begin
                n_errors++;
                $display("FAIL stall_resume cyc %0d: got v=%b pc=%h i=%h, want v=1 pc=%h i=%h",
                         s_cyc, s_valid, s_pc, s_instr, held + 32'(4 * i), e_instr);
            end
            n_checks++;
            if (s_req !== e_req || (e_req && s_addr !== e_addr)) begin
                n_errors++;
                $display("FAIL stall_req cyc %0d: got req=%b addr=%h, want req=%b addr=%h",
                         s_cyc, s_req, s_addr, e_req, e_addr);
            end
        end
    endtask

    task automatic test_redirect();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        for (int i = 0; i < 7; i++) begin
            tick();
            redirect_valid = 1'b0;
            n_checks++;
            if (s_valid !== e_valid || s_pc !== e_pc || s_instr !== e_instr
                || s_req !== e_req || (e_req && s_addr !== e_addr)) begin
                n_errors++;
                $display("FAIL redirect_model +%0d: got v=%b pc=%h req=%b addr=%h, want v=%b pc=%h req=%b addr=%h",
                         i, s_valid, s_pc, s_req, s_addr, e_valid, e_pc, e_req, e_addr);
            end
            if (i == 1) begin
                n_checks++;
                if (s_req !== 1'b1 || s_addr !== 32'h100) begin
                    n_errors++;
                    $display("FAIL redirect_addr: got req=%b addr=%h, want 1/00000100", s_req, s_addr);
                end
            end
            if (i == 1 || i == 2) begin
                n_checks++;
                if (s_valid !== 1'b0) begin
                    n_errors++;
                    $display("FAIL redirect_flush +%0d: got v=%b, want 0", i, s_valid);
                end
            end
            if (i == 3) begin
                n_checks++;
                if (s_valid !== 1'b1 || s_pc !== 32'h100 || s_instr !== mem(32'h100)) begin
                    n_errors++;
                    $display("FAIL redirect_target: got v=%b pc=%h i=%h, want 1/00000100/%h",
                             s_valid, s_pc, s_instr, mem(32'h100));
                end
            end
        end
    endtask

    task automatic test_gnt_low();
        logic [31:0] addr0;
        imem_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 0) addr0 = s_addr;
            n_checks++;
            if (s_req !== 1'b1 || s_addr !== addr0 || s_req !== e_req || s_addr !== e_addr
                || s_valid !== e_valid || s_pc !== e_pc) begin
                n_errors++;
                $display("FAIL gnt_low_hold +%0d: got req=%b addr=%h v=%b pc=%h, want req=1 addr=%h v=%b pc=%h",
                         i, s_req, s_addr, s_valid, s_pc, addr0, e_valid, e_pc);
            end
        end
        imem_gnt = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i == 0) begin
                n_checks++;
                if (s_valid !== 1'b0) begin
                    n_errors++;
                    $display("FAIL gnt_low_drain: got v=%b, want 0", s_valid);
                end
            end
            n_checks++;
            if (s_valid !== e_valid || s_pc !== e_pc || s_instr !== e_instr
                || s_req !== e_req || (e_req && s_addr !== e_addr)) begin
                n_errors++;
                $display("FAIL gnt_low_resume +%0d: got v=%b pc=%h req=%b addr=%h, want v=%b pc=%h req=%b addr=%h",
                         i, s_valid, s_pc, s_req, s_addr, e_valid, e_pc, e_req, e_addr);
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] want [3];
        want[0] = 32'hFFFF_FFF8; want[1] = 32'hFFFF_FFFC; want[2] = 32'h0000_0000;
        reset = 1'b1;
        model_reset();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (s_cyc >= 3) begin
                n_checks++;
                if (s2_valid !== 1'b1 || s2_pc !== want[s_cyc - 3]) begin
                    n_errors++;
                    $display("FAIL wrap_pc cyc %0d: got v=%b pc=%h, want 1/%h",
                             s_cyc, s2_valid, s2_pc, want[s_cyc - 3]);
                end
            end
            n_checks++;
            if (s_valid !== e_valid || s_pc !== e_pc || s_req !== e_req) begin
                n_errors++;
                $display("FAIL wrap_main cyc %0d: got v=%b pc=%h req=%b, want v=%b pc=%h req=%b",
                         s_cyc, s_valid, s_pc, s_req, e_valid, e_pc, e_req);
            end
        end
    endtask

    task automatic test_reset_midstream();
        // A response for a pre-reset grant is on the bus while the pulse hits.
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h0 || fetch_valid !== 1'b0
            || fetch_pc !== 32'h0 || fetch_instr !== NOP) begin
            n_errors++;
            $display("FAIL midreset_outputs: got req=%b addr=%h v=%b pc=%h i=%h, want 0/0/0/0/%h",
                     imem_req, imem_addr, fetch_valid, fetch_pc, fetch_instr, NOP);
        end
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++;
            if (s_valid !== e_valid || s_pc !== e_pc || s_instr !== e_instr
                || s_req !== e_req || (e_req && s_addr !== e_addr)
                || (s_cyc < 3 && s_valid !== 1'b0)) begin
                n_errors++;
                $display("FAIL midreset_after cyc %0d: got v=%b pc=%h req=%b addr=%h, want v=%b pc=%h req=%b addr=%h",
                         s_cyc, s_valid, s_pc, s_req, s_addr, e_valid, e_pc, e_req, e_addr);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            stall          = ($urandom_range(9) < 3);
            imem_gnt       = ($urandom_range(9) < 7);
            redirect_valid = ($urandom_range(24) == 0);
            redirect_pc    = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                                      : $urandom();
            tick();
            n_checks++;
            if (s_valid !== e_valid || s_pc !== e_pc || s_instr !== e_instr) begin
                n_errors++;
                $display("FAIL random_out cyc %0d: got v=%b pc=%h i=%h, want v=%b pc=%h i=%h",
                         s_cyc, s_valid, s_pc, s_instr, e_valid, e_pc, e_instr);
            end
            n_checks++;
            if (s_req !== e_req || (e_req && s_addr !== e_addr)) begin
                n_errors++;
                $display("FAIL random_req cyc %0d: got req=%b addr=%h, want req=%b addr=%h",
                         s_cyc, s_req, s_addr, e_req, e_addr);
            end
        end
        stall = 1'b0; redirect_valid = 1'b0; imem_gnt = 1'b1;
    endtask

    initial begin
        test_reset();
        test_steady();
        test_stall();
        test_redirect();
        test_gnt_low();
        test_wrap();
        tick();
        tick();
        test_reset_midstream();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
